tick_gen: RTL and testbench

TICK_GEN -- requirements
Module: tick_gen

---
 rtl/tick_gen.sv | 114 +++++++++++
 tb/tb_tick_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen.sv
// Fractional tick generator: a phase accumulator yields BASE_HZ base ticks per CLK_HZ run cycles
// with no drift, plus a once-per-second tick, a sub-second count and a run/pause/oneshot FSM.
module tick_gen #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned BASE_HZ = 100
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       clear,
  input  logic                       mode_oneshot,
  output logic                       tick_base,
  output logic                       tick_1hz,
  output logic [$clog2(BASE_HZ)-1:0] subsec,
  output logic                       running,
  output logic                       done
);

  localparam int unsigned AccW = $clog2(CLK_HZ + BASE_HZ);
  localparam int unsigned SubW = $clog2(BASE_HZ);
  localparam logic [AccW-1:0] AccInc = AccW'(BASE_HZ);
  localparam logic [AccW-1:0] AccMod = AccW'(CLK_HZ);
  localparam logic [SubW-1:0] SubMax = SubW'(BASE_HZ - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e          state_q, state_d;
  logic [AccW-1:0] acc_q, acc_d, acc_sum;
  logic [SubW-1:0] subsec_q, subsec_d;
  logic            tick_base_q, tick_base_d;
  logic            tick_1hz_q, tick_1hz_d;
  logic            running_q, done_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    subsec_d    = subsec_q;
    tick_base_d = 1'b0;
    tick_1hz_d  = 1'b0;
    acc_sum     = acc_q + AccInc;

    if (clear) begin
      state_d  = StIdle;
      acc_d    = '0;
      subsec_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!stop && start) state_d = StRun;
        end
        StRun: begin
          // acc + BASE_HZ never exceeds CLK_HZ + BASE_HZ - 1, so AccW bits suffice
          if (acc_sum >= AccMod) begin
            acc_d       = acc_sum - AccMod;
            tick_base_d = 1'b1;
            if (subsec_q == SubMax) begin
              subsec_d   = '0;
              tick_1hz_d = 1'b1;
            end else begin
              subsec_d = subsec_q + 1'b1;
            end
          end else begin
            acc_d = acc_sum;
          end
          // The tick on this edge is always emitted; state change takes effect afterwards
          if (tick_1hz_d && mode_oneshot) begin
            state_d = StDone;
          end else if (stop) begin
            state_d = StPause;
          end
        end
        StPause: begin
          if (!stop && start) state_d = StRun;
        end
        StDone: begin
          if (!stop && start) begin
            state_d  = StRun;
            acc_d    = '0;
            subsec_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      subsec_q    <= '0;
      tick_base_q <= 1'b0;
      tick_1hz_q  <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      subsec_q    <= subsec_d;
      tick_base_q <= tick_base_d;
      tick_1hz_q  <= tick_1hz_d;
      running_q   <= (state_d == StRun);
      done_q      <= (state_d == StDone);
    end
  end

  assign tick_base = tick_base_q;
  assign tick_1hz  = tick_1hz_q;
  assign subsec    = subsec_q;
  assign running   = running_q;
  assign done      = done_q;

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen: stimulus queues expected ticks (cycle, tick_1hz, subsec),
// per-instance monitors pop and compare on every observed tick_base pulse.
module tb_tick_gen;

  typedef struct {
    int cyc;
    int t1;
    int sub;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic start_a, stop_a, clear_a, oneshot_a;
  logic tb_a, t1_a, run_a, done_a;
  logic [0:0] sub_a;
  logic start_b, stop_b, clear_b, oneshot_b;
  logic tb_b, t1_b, run_b, done_b;
  logic [1:0] sub_b;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   base;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tick_gen #(.CLK_HZ(10), .BASE_HZ(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .stop(stop_a), .clear(clear_a),
    .mode_oneshot(oneshot_a), .tick_base(tb_a), .tick_1hz(t1_a), .subsec(sub_a),
    .running(run_a), .done(done_a)
  );

  tick_gen #(.CLK_HZ(10), .BASE_HZ(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .stop(stop_b), .clear(clear_b),
    .mode_oneshot(oneshot_b), .tick_base(tb_b), .tick_1hz(t1_b), .subsec(sub_b),
    .running(run_b), .done(done_b)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_a(input int c, input int t1, input int sub);
    exp_t e;
    e.cyc = c; e.t1 = t1; e.sub = sub;
    qa.push_back(e);
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    base = cyc;
  endtask

  task automatic do_clear_a();
    clear_a = 1'b1;
    step(1);
    clear_a = 1'b0;
  endtask

  // Monitor for instance A
  always @(negedge clk) begin
    if (t1_a) check("a_1hz_with_base", int'(tb_a), 1);
    if (tb_a) begin
      if (qa.size() == 0) begin
        check("a_unexpected_tick", int'(qa.size()), 1);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("a_tick_cycle", cyc, e.cyc);
        check("a_tick_1hz", int'(t1_a), e.t1);
        check("a_subsec", int'(sub_a), e.sub);
      end
    end
  end

  // Monitor for instance B
  always @(negedge clk) begin
    if (t1_b) check("b_1hz_with_base", int'(tb_b), 1);
    if (tb_b) begin
      if (qb.size() == 0) begin
        check("b_unexpected_tick", int'(qb.size()), 1);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("b_tick_cycle", cyc, e.cyc);
        check("b_tick_1hz", int'(t1_b), e.t1);
        check("b_subsec", int'(sub_b), e.sub);
      end
    end
  end

  initial begin
    reset_n = 1'b1;
    {start_a, stop_a, clear_a, oneshot_a} = '0;
    {start_b, stop_b, clear_b, oneshot_b} = '0;
    #2 reset_n = 1'b0;
    #2;
    check("rst_tick_base", int'(tb_a), 0);
    check("rst_tick_1hz", int'(t1_a), 0);
    check("rst_subsec", int'(sub_a), 0);
    check("rst_running", int'(run_a), 0);
    check("rst_done", int'(done_a), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(3);
    check("idle_after_reset", int'(run_a), 0);

    // Continuous run, 25 RUN edges
    pulse_start_a();
    for (int k = 1; k <= 5; k++) push_a(base + 5 * k, (k % 2 == 0) ? 1 : 0, k % 2);
    step(2);
    check("running_in_run", int'(run_a), 1);
    step(23);
    stop_a = 1'b1;
    step(1);
    stop_a = 1'b0;
    check("stop_leaves_run", int'(run_a), 0);
    do_clear_a();
    check("clear_subsec", int'(sub_a), 0);

    // Pause after RUN edge 3, hold 7 cycles, resume
    pulse_start_a();
    step(2);
    stop_a = 1'b1;
    step(1);
    stop_a = 1'b0;
    step(7);
    check("paused_not_running", int'(run_a), 0);
    pulse_start_a();
    push_a(base + 2, 0, 1);
    step(3);
    do_clear_a();

    // Oneshot: halt after first tick_1hz, then restart from zero
    oneshot_a = 1'b1;
    pulse_start_a();
    push_a(base + 5, 0, 1);
    push_a(base + 10, 1, 0);
    step(11);
    check("oneshot_done", int'(done_a), 1);
    check("oneshot_not_running", int'(run_a), 0);
    step(6);
    check("oneshot_still_done", int'(done_a), 1);
    pulse_start_a();
    check("restart_done_clear", int'(done_a), 0);
    check("restart_running", int'(run_a), 1);
    check("restart_subsec", int'(sub_a), 0);
    push_a(base + 5, 0, 1);
    step(6);
    oneshot_a = 1'b0;
    do_clear_a();

    // start+stop+clear in RUN, then start+stop in PAUSE
    pulse_start_a();
    step(3);
    {start_a, stop_a, clear_a} = 3'b111;
    step(1);
    {start_a, stop_a, clear_a} = 3'b000;
    check("ssc_running", int'(run_a), 0);
    check("ssc_done", int'(done_a), 0);
    check("ssc_subsec", int'(sub_a), 0);
    pulse_start_a();
    push_a(base + 5, 0, 1);
    step(5);
    stop_a = 1'b1;
    step(1);
    stop_a = 1'b0;
    check("stop_after_tick", int'(run_a), 0);
    {start_a, stop_a} = 2'b11;
    step(2);
    {start_a, stop_a} = 2'b00;
    check("pause_start_stop", int'(run_a), 0);
    pulse_start_a();
    push_a(base + 4, 1, 0);
    step(5);
    do_clear_a();

    // Asynchronous reset mid-RUN with subsec=1
    pulse_start_a();
    push_a(base + 5, 0, 1);
    step(6);
    check("pre_reset_subsec", int'(sub_a), 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_tick_base", int'(tb_a), 0);
    check("arst_subsec", int'(sub_a), 0);
    check("arst_running", int'(run_a), 0);
    check("arst_done", int'(done_a), 0);
    check("arst_tick_1hz", int'(t1_a), 0);
    step(1);
    @(negedge clk);
    reset_n = 1'b1;
    step(4);
    check("post_reset_idle", int'(run_a), 0);
    pulse_start_a();
    push_a(base + 5, 0, 1);
    step(6);
    do_clear_a();

    // BASE_HZ=3: intervals 4,3,3 repeating, 9 ticks in 30 RUN edges
    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    base = cyc;
    begin
      int offs[9] = '{4, 7, 10, 14, 17, 20, 24, 27, 30};
      for (int i = 0; i < 9; i++) begin
        exp_t e;
        e.cyc = base + offs[i];
        e.t1  = (i % 3 == 2) ? 1 : 0;
        e.sub = (i + 1) % 3;
        qb.push_back(e);
      end
    end
    step(31);

    step(2);
    check("a_pending_ticks", int'(qa.size()), 0);
    check("b_pending_ticks", int'(qb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
